// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Run controller for the up/down counter datapath. Divides clk into a
//   programmable count-enable tick, drives the counter direction flag, keeps
//   a shadow of the commanded count and pulses `done` when a run completes.
//   Sequences: up, down, ping-pong; each repeated for a programmed number of
//   passes.
//
// Build option:
//   COUNTER_SEQ_PASSES_EN  defined   -> `passes` / `pass_cnt` functional
//                          undefined -> one pass per start, pass_cnt = 0,
//                                       no pass counter flops
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   start          level, sampled in IDLE only
//   stop           abort request, sampled in RUN
//   mode[1:0]      00 up, 01 down, 10 ping-pong, 11 up
//   div_val        tick period minus 1
//   limit          sequence end value (clamped to C_MAX-1 at latch)
//   passes         pass count, 0 = run until stop
//   cnt_en         one-cycle tick to the counter enable
//   reverse        1 = counter counting down
//   position       shadow of the commanded count
//   busy           high in RUN
//   done           one-cycle completion pulse
//   pass_cnt       completed passes in the current run

module counter_sequencer #(
  parameter  int C_MAX = 256,
  parameter  int DIV_W = 16,
  localparam int CW    = $clog2(C_MAX)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div_val,
  input  logic [CW-1:0]    limit,
  input  logic [7:0]       passes,
  output logic             cnt_en,
  output logic             reverse,
  output logic [CW-1:0]    position,
  output logic             busy,
  output logic             done,
  output logic [7:0]       pass_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int            CW1       = CW + 1;
  localparam logic [CW:0]   CMAX_EXT  = CW1'(C_MAX);
  localparam logic [CW-1:0] LIMIT_MAX = CW'(C_MAX - 1);

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [DIV_W-1:0] div_val_q, div_val_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CW-1:0]    limit_q, limit_d;
  logic [CW-1:0]    position_q, position_d;
  logic             reverse_q, reverse_d;
  logic             cnt_en_q, cnt_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Clamp is only reachable when C_MAX is not a power of two.
  logic [CW-1:0] limit_clamped;
  assign limit_clamped = ({1'b0, limit} >= CMAX_EXT) ? LIMIT_MAX : limit;

  logic in_down, mode_down, mode_pp;
  assign in_down   = (mode == 2'b01);
  assign mode_down = (mode_q == 2'b01);
  assign mode_pp   = (mode_q == 2'b10);

  // Values reloaded at the start of every pass.
  logic [CW-1:0] start_pos;
  logic          start_rev;
  assign start_pos = mode_down ? limit_q : '0;
  assign start_rev = mode_down;

  // One step of the sequence, applied when a tick is taken.
  logic [CW-1:0] step_pos;
  logic          step_rev;
  logic          pass_end;

  always_comb begin
    step_pos = position_q;
    step_rev = reverse_q;
    pass_end = 1'b0;
    if (mode_down) begin
      if (position_q == '0) pass_end = 1'b1;
      else                  step_pos = position_q - 1'b1;
    end else if (mode_pp) begin
      if (!reverse_q) begin
        if (position_q == limit_q) begin
          // Turn-around; a zero-length ping-pong has nowhere to turn.
          if (limit_q == '0) begin
            pass_end = 1'b1;
          end else begin
            step_rev = 1'b1;
            step_pos = position_q - 1'b1;
          end
        end else begin
          step_pos = position_q + 1'b1;
        end
      end else begin
        if (position_q == '0) pass_end = 1'b1;
        else                  step_pos = position_q - 1'b1;
      end
    end else begin
      if (position_q == limit_q) pass_end = 1'b1;
      else                       step_pos = position_q + 1'b1;
    end
  end

`ifdef COUNTER_SEQ_PASSES_EN
  logic [7:0] passes_q, passes_d;
  logic [7:0] pass_cnt_q, pass_cnt_d;
  logic [7:0] pass_cnt_inc;
  logic       run_final;

  assign pass_cnt_inc = (pass_cnt_q == 8'hFF) ? 8'hFF : pass_cnt_q + 1'b1;
  assign run_final    = pass_end && (passes_q != 8'd0) && (pass_cnt_inc == passes_q);
  assign pass_cnt     = pass_cnt_q;
`else
  logic run_final;
  logic unused_passes;

  assign run_final     = pass_end;
  assign unused_passes = ^passes;
  assign pass_cnt      = 8'd0;
`endif

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    div_val_d  = div_val_q;
    limit_d    = limit_q;
    div_d      = div_q;
    position_d = position_q;
    reverse_d  = reverse_q;
    cnt_en_d   = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
`ifdef COUNTER_SEQ_PASSES_EN
    passes_d   = passes_q;
    pass_cnt_d = pass_cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d     = mode;
          div_val_d  = div_val;
          limit_d    = limit_clamped;
          div_d      = '0;
          position_d = in_down ? limit_clamped : '0;
          reverse_d  = in_down;
          busy_d     = 1'b1;
          // cnt_en is registered, so the first tick is decided one cycle early.
          cnt_en_d   = (div_val == '0);
          state_d    = S_RUN;
`ifdef COUNTER_SEQ_PASSES_EN
          passes_d   = passes;
          pass_cnt_d = 8'd0;
`endif
        end
      end

      S_RUN: begin
        if (stop) begin
          // Abort: the tick in this cycle has no effect, except that a run-
          // completing tick still counts its pass.
          state_d = S_IDLE;
          div_d   = '0;
`ifdef COUNTER_SEQ_PASSES_EN
          if (cnt_en_q && run_final) pass_cnt_d = pass_cnt_inc;
`endif
        end else begin
          busy_d   = 1'b1;
          div_d    = cnt_en_q ? '0 : div_q + 1'b1;
          cnt_en_d = (div_d == div_val_q);
          if (cnt_en_q) begin
            if (pass_end) begin
`ifdef COUNTER_SEQ_PASSES_EN
              pass_cnt_d = pass_cnt_inc;
`endif
              if (run_final) begin
                // Position and direction hold their last commanded values.
                state_d  = S_DONE;
                busy_d   = 1'b0;
                cnt_en_d = 1'b0;
                done_d   = 1'b1;
              end else begin
                position_d = start_pos;
                reverse_d  = start_rev;
              end
            end else begin
              position_d = step_pos;
              reverse_d  = step_rev;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= 2'b00;
      div_val_q  <= '0;
      limit_q    <= '0;
      div_q      <= '0;
      position_q <= '0;
      reverse_q  <= 1'b0;
      cnt_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef COUNTER_SEQ_PASSES_EN
      passes_q   <= 8'd0;
      pass_cnt_q <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      div_val_q  <= div_val_d;
      limit_q    <= limit_d;
      div_q      <= div_d;
      position_q <= position_d;
      reverse_q  <= reverse_d;
      cnt_en_q   <= cnt_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef COUNTER_SEQ_PASSES_EN
      passes_q   <= passes_d;
      pass_cnt_q <= pass_cnt_d;
`endif
    end
  end

  assign cnt_en   = cnt_en_q;
  assign reverse  = reverse_q;
  assign position = position_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Testbench for counter_sequencer. A non-power-of-two C_MAX is used so the
// limit clamp is reachable. Expected ticks (cycle, position, reverse) and
// completions are queued when a run is launched; a negedge monitor pops and
// compares them whenever the DUT shows cnt_en or done.

module tb_counter_sequencer;
  localparam int C_MAX = 200;
  localparam int DIV_W = 16;
  localparam int CW    = $clog2(C_MAX);
`ifdef COUNTER_SEQ_PASSES_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic             clk, rst_n, start, stop;
  logic [1:0]       mode_i;
  logic [DIV_W-1:0] div_val_i;
  logic [CW-1:0]    limit_i;
  logic [7:0]       passes_i;
  logic             cnt_en, reverse, busy, done;
  logic [CW-1:0]    position;
  logic [7:0]       pass_cnt;

  counter_sequencer #(.C_MAX(C_MAX), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode_i),
    .div_val(div_val_i), .limit(limit_i), .passes(passes_i), .cnt_en(cnt_en),
    .reverse(reverse), .position(position), .busy(busy), .done(done),
    .pass_cnt(pass_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int cyc; int pos; int rev; } tick_t;
  typedef struct { int cyc; int pos; int rev; int pc; } done_t;
  tick_t tq[$];
  done_t dq[$];
  bit    mon_en = 1'b0;

  always @(negedge clk) begin
    tick_t te;
    done_t de;
    if (mon_en) begin
      if (cnt_en) begin
        if (tq.size() != 0) begin
          te = tq.pop_front();
          check("tick_cycle", cyc, te.cyc);
          check("tick_pos", position, te.pos);
          check("tick_rev", reverse, te.rev);
        end else if (!stop) begin
          check("unexpected_tick", cnt_en, 0);
        end
      end
      if (done) begin
        if (dq.size() != 0) begin
          de = dq.pop_front();
          check("done_cycle", cyc, de.cyc);
          check("done_pos", position, de.pos);
          check("done_rev", reverse, de.rev);
          check("done_pass_cnt", pass_cnt, de.pc);
          check("done_busy", busy, 0);
        end else begin
          check("unexpected_done", done, 0);
        end
      end
    end
  end

  // Reference: one pass as a list of (position, reverse) seen on each tick.
  int pass_pos[$];
  int pass_rev[$];

  task automatic build_pass(input int mode, input int lim);
    pass_pos.delete();
    pass_rev.delete();
    if (mode == 1) begin
      for (int p = lim; p >= 0; p--) begin pass_pos.push_back(p); pass_rev.push_back(1); end
    end else if (mode == 2) begin
      for (int p = 0; p <= lim; p++) begin pass_pos.push_back(p); pass_rev.push_back(0); end
      for (int p = lim - 1; p >= 0; p--) begin pass_pos.push_back(p); pass_rev.push_back(1); end
    end else begin
      for (int p = 0; p <= lim; p++) begin pass_pos.push_back(p); pass_rev.push_back(0); end
    end
  endtask

  function automatic int eff_limit(input int lim);
    return (lim >= C_MAX) ? C_MAX - 1 : lim;
  endfunction

  function automatic int eff_passes(input int p);
    return PE ? p : 1;
  endfunction

  function automatic int tick_cyc(input int s, input int dv, input int i);
    return s + dv + i * (dv + 1);
  endfunction

  task automatic push_run(input int s, input int dv, input int n, input bit with_done, input int pc);
    tick_t te;
    done_t de;
    int len;
    len = pass_pos.size();
    for (int i = 0; i < n; i++) begin
      te.cyc = tick_cyc(s, dv, i);
      te.pos = pass_pos[i % len];
      te.rev = pass_rev[i % len];
      tq.push_back(te);
    end
    if (with_done) begin
      de.cyc = tick_cyc(s, dv, n - 1) + 1;
      de.pos = pass_pos[len - 1];
      de.rev = pass_rev[len - 1];
      de.pc  = pc;
      dq.push_back(de);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask

  task automatic drain_check();
    repeat (3) @(posedge clk);
    #1;
    check("ticks_left", tq.size(), 0);
    check("dones_left", dq.size(), 0);
    tq.delete();
    dq.delete();
  endtask

  // stop_k >= 0: stop sampled on the edge after the stop_k-th tick.
  // stop_final: stop raised during the run-completing tick.
  task automatic run_seq(input int mode, input int dv, input int lim, input int passes,
                         input int stop_k, input bit stop_final, input bit poke_start);
    int le, pe, len, n, s, last;
    le = eff_limit(lim);
    pe = eff_passes(passes);
    build_pass(mode, le);
    len  = pass_pos.size();
    last = len - 1;
    n = (stop_k >= 0) ? stop_k : pe * len;

    @(negedge clk);
    mode_i = 2'(mode); div_val_i = DIV_W'(dv); limit_i = CW'(lim); passes_i = 8'(passes);
    start = 1'b1;
    @(posedge clk); #1;
    s = cyc;
    start = 1'b0;
    // Latched config must not follow later input changes.
    mode_i = 2'($urandom); div_val_i = DIV_W'($urandom); limit_i = CW'($urandom);
    passes_i = 8'($urandom);
    push_run(s, dv, n, (stop_k < 0) && !stop_final, PE ? pe : 0);
    check("busy_after_start", busy, 1);

    if (poke_start) begin
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end

    if (stop_k >= 0) begin
      wait_cyc(tick_cyc(s, dv, stop_k - 1) + 1);
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      check("stop_busy", busy, 0);
      check("stop_done", done, 0);
      check("stop_pos", position, pass_pos[stop_k % len]);
      check("stop_rev", reverse, pass_rev[stop_k % len]);
      check("stop_pass_cnt", pass_cnt, PE ? ((stop_k / len > 255) ? 255 : stop_k / len) : 0);
    end else if (stop_final) begin
      wait_cyc(tick_cyc(s, dv, n - 1));
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      check("final_stop_busy", busy, 0);
      check("final_stop_done", done, 0);
      check("final_stop_pos", position, pass_pos[last]);
      check("final_stop_rev", reverse, pass_rev[last]);
      check("final_stop_pass_cnt", pass_cnt, PE ? pe : 0);
    end else begin
      wait_cyc(tick_cyc(s, dv, n - 1) + 2);
      check("idle_after_done_busy", busy, 0);
    end
    drain_check();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected under 100000", cyc);
    $fatal(1);
  end

  initial begin
    int s, mode, dv, lim, ps, len, sk;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    mode_i = '0; div_val_i = '0; limit_i = '0; passes_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cnt_en", cnt_en, 0);
    check("rst_reverse", reverse, 0);
    check("rst_position", position, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass_cnt", pass_cnt, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    run_seq(0, 0, 3, 1, -1, 0, 0);                  // up, basic
    run_seq(2, 2, 2, 2, -1, 0, 0);                  // ping-pong, 2 passes
    if (PE) run_seq(1, 1, 5, 0, 8, 0, 0);           // down, free-running, stop
    else    run_seq(1, 1, 5, 0, 3, 0, 0);
    run_seq(0, 0, 250, 1, -1, 0, 0);                // limit clamp
    run_seq(3, 1, 4, 1, -1, 0, 1);                  // mode 11, start poked mid-run
    run_seq(0, 0, 0, 1, -1, 0, 0);                  // up, zero limit
    run_seq(2, 1, 0, 2, -1, 0, 0);                  // ping-pong, zero limit
    run_seq(0, 1, 3, 2, -1, 1, 0);                  // stop on the final tick
    run_seq(1, 0, 6, 1, 4, 0, 0);                   // stop with a tick every cycle
    if (PE) run_seq(0, 0, 0, 0, 300, 0, 0);         // pass_cnt saturation

    // start held through done: a new run launches from IDLE.
    @(negedge clk);
    mode_i = 2'd0; div_val_i = '0; limit_i = CW'(1); passes_i = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    s = cyc;
    build_pass(0, 1);
    push_run(s, 0, 2, 1, PE ? 1 : 0);
    push_run(s + 4, 0, 2, 1, PE ? 1 : 0);
    wait_cyc(s + 3);
    check("held_start_idle_busy", busy, 0);
    @(posedge clk); #1;
    check("held_start_restart_busy", busy, 1);
    start = 1'b0;
    wait_cyc(s + 8);
    drain_check();

    // Reset in the middle of a run.
    @(negedge clk);
    mode_i = 2'd0; div_val_i = DIV_W'(1); limit_i = CW'(20); passes_i = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    s = cyc;
    start = 1'b0;
    build_pass(0, 20);
    push_run(s, 1, 21, 1, PE ? 1 : 0);
    wait_cyc(tick_cyc(s, 1, 7));
    check("pre_reset_pos", position, 7);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_cnt_en", cnt_en, 0);
    check("midrst_reverse", reverse, 0);
    check("midrst_position", position, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_pass_cnt", pass_cnt, 0);
    rst_n = 1'b1;
    tq.delete();
    dq.delete();
    drain_check();

    // Randomized runs.
    for (int r = 0; r < 14; r++) begin
      mode = $urandom_range(0, 3);
      dv   = $urandom_range(0, 3);
      lim  = $urandom_range(0, 12);
      ps   = $urandom_range(1, 3);
      len  = (mode == 2) ? 2 * lim + 1 : lim + 1;
      sk   = -1;
      if ($urandom_range(0, 2) == 0 && eff_passes(ps) * len > 1)
        sk = $urandom_range(1, eff_passes(ps) * len - 1);
      run_seq(mode, dv, lim, ps, sk, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
